// File: rtl/seq_arith_unit.sv
// Registered add/sub/inc/dec/slt unit with an iterative shift-add multiplier.
// Single-cycle ops complete one edge after acceptance; MUL holds off issue for WIDTH edges.
module seq_arith_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_INC = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_DEC = 3'b101;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]     count;

    logic                 accept;
    logic                 mul_accept;
    logic                 mul_done;
    logic                 load_result;

    logic                 use_one;
    logic                 invert;
    logic [WIDTH-1:0]     b_src;
    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       sum;
    logic                 add_ovf;

    logic [WIDTH-1:0]     res_next;
    logic                 cout_next;
    logic                 ovf_next;

    assign in_ready   = (state == S_IDLE);
    assign accept     = start && in_ready;
    assign mul_accept = accept && (op == OP_MUL);
    assign mul_done   = (state == S_MUL) && (count == CNT_W'(WIDTH - 1));
    assign load_result = mul_done || (accept && (op != OP_MUL));

    // Shared adder: INC/DEC substitute constant 1; op[2] (and SLT) selects A + ~b + 1.
    always_comb begin
        use_one = op[0] & ~op[1];
        invert  = op[2] | (op == OP_SLT);
        b_src   = use_one ? WIDTH'(1) : B;
        b_eff   = invert ? ~b_src : b_src;
        sum     = {1'b0, A} + {1'b0, b_eff} + (WIDTH + 1)'(invert);
        add_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (mul_accept) state_next = S_MUL;
            S_MUL:  if (mul_done)   state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        res_next  = '0;
        cout_next = 1'b0;
        ovf_next  = 1'b0;
        if (state == S_MUL) begin
            res_next  = acc_next[WIDTH-1:0];
            cout_next = |acc_next[2*WIDTH-1:WIDTH];
            ovf_next  = |acc_next[2*WIDTH-1:WIDTH];
        end else begin
            unique case (op)
                OP_ADD, OP_INC, OP_SUB, OP_DEC: begin
                    res_next  = sum[WIDTH-1:0];
                    cout_next = sum[WIDTH];
                    ovf_next  = add_ovf;
                end
                OP_SLT: begin
                    res_next  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
                    cout_next = sum[WIDTH];
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= load_result;
            if (load_result) begin
                result   <= res_next;
                cout     <= cout_next;
                overflow <= ovf_next;
                zero     <= (res_next == '0);
                negative <= res_next[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (mul_accept) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            count  <= '0;
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Bench for seq_arith_unit (WIDTH=32): directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_seq_arith_unit;

    localparam logic [2:0] ADD = 3'b000, INC = 3'b001, MUL = 3'b010, SLT = 3'b011;
    localparam logic [2:0] SUB = 3'b100, DEC = 3'b101, RS6 = 3'b110, RS7 = 3'b111;
    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, cout, zero, negative, overflow;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    seq_arith_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
        .in_ready(in_ready), .out_valid(out_valid), .result(result),
        .cout(cout), .zero(zero), .negative(negative), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t            e;
        longint          sx, sy, s;
        longint unsigned u;
        e = '0;
        if (o == INC || o == DEC) y = 32'd1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            ADD, INC: begin
                u   = 64'(x) + 64'(y);
                e.r = u[31:0];
                e.c = u[32];
                s   = sx + sy;
                e.v = (s > S_MAX) || (s < S_MIN);
            end
            SUB, DEC: begin
                e.r = x - y;
                e.c = (x >= y);
                s   = sx - sy;
                e.v = (s > S_MAX) || (s < S_MIN);
            end
            SLT: begin
                e.r = (sx < sy) ? 32'd1 : 32'd0;
                e.c = (x >= y);
            end
            MUL: begin
                u   = 64'(x) * 64'(y);
                e.r = u[31:0];
                e.c = (u[63:32] != 0);
                e.v = e.c;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".result"},    result,          e.r);
        check({tag, ".cout"},      32'(cout),       32'(e.c));
        check({tag, ".overflow"},  32'(overflow),   32'(e.v));
        check({tag, ".zero"},      32'(zero),       32'(e.r == 0));
        check({tag, ".negative"},  32'(negative),   32'(e.r[31]));
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // One single-cycle op: result expected at the next sample, then out_valid drops.
    task automatic single(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        drive(o, x, y);
        @(negedge clk);
        start = 1'b0;
        check_out(tag, model(o, x, y));
        @(negedge clk);
        check({tag, ".pulse_end"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_mul(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input bit poke, input bit rsv_after);
        int cyc;
        @(negedge clk);
        drive(MUL, x, y);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, ".busy"}, 32'(in_ready), 32'd0);
        while (!out_valid && cyc < 100) begin
            if (poke && cyc == 5) begin
                check({tag, ".busy_poke"}, 32'(in_ready), 32'd0);
                drive(ADD, 32'd1, 32'd1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(cyc), 32'd33);
        check_out(tag, model(MUL, x, y));
        if (rsv_after) begin
            check({tag, ".ready_again"}, 32'(in_ready), 32'd1);
            drive(RS7, $urandom, $urandom);
            @(negedge clk);
            start = 1'b0;
            check_out({tag, ".rsv"}, model(RS7, a, b));
        end
        @(negedge clk);
        check({tag, ".pulse_end"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [2:0]  ops [3];
        logic [31:0] as  [3];
        logic [31:0] bs  [3];
        bit          saw_valid;
        logic [2:0]  pick [7];

        // Reset state
        #3;
        check("rst.result", result, 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.flags", {28'd0, cout, zero, negative, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst.in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a multiply, after a nonzero result is held
        single("pre_add", ADD, 32'd3, 32'd4);
        @(negedge clk);
        drive(MUL, 32'd1234, 32'd5678);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.result", result, 32'd0);
        check("midrst.flags", {28'd0, cout, zero, negative, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_valid |= out_valid;
        end
        check("midrst.no_valid", 32'(saw_valid), 32'd0);

        // Adder carry/overflow corners
        single("add_wrap", ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        single("add_ovf",  ADD, 32'h7FFF_FFFF, 32'h0000_0001);

        // Back-to-back SUB / DEC / INC with a continuous out_valid train
        ops = '{SUB, DEC, INC};
        as  = '{32'd5, 32'd0, 32'h7FFF_FFFF};
        bs  = '{32'd7, 32'd0, 32'd0};
        @(negedge clk);
        drive(ops[0], as[0], bs[0]);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            check_out($sformatf("b2b%0d", i - 1), model(ops[i-1], as[i-1], bs[i-1]));
            drive(ops[i], as[i], bs[i]);
        end
        @(negedge clk);
        start = 1'b0;
        check_out("b2b2", model(ops[2], as[2], bs[2]));
        @(negedge clk);
        check("b2b.pulse_end", 32'(out_valid), 32'd0);

        // Signed compare
        single("slt_neg1_1", SLT, 32'hFFFF_FFFF, 32'd1);
        single("slt_1_neg1", SLT, 32'd1, 32'hFFFF_FFFF);
        single("slt_min_max", SLT, 32'h8000_0000, 32'h7FFF_FFFF);

        // Multiplies: high-half overflow, small product with ignored start, reserved follow-up
        run_mul("mul_hi", 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
        run_mul("mul_small", 32'd123, 32'd456, 1'b1, 1'b1);
        single("rsv6", RS6, 32'h1234_5678, 32'h9ABC_DEF0);

        // Random mix
        pick = '{ADD, INC, SUB, DEC, SLT, RS6, RS7};
        for (int i = 0; i < 60; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) y = y >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) begin
                run_mul($sformatf("rnd%0d.mul", i), x, y, 1'b0, 1'b0);
            end else begin
                logic [2:0] o;
                o = pick[$urandom_range(0, 6)];
                single($sformatf("rnd%0d.op%0d", i, o), o, x, y);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
